// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with a registered read stage,
// write-to-read bypass, and a sequential clear engine that zeroes the array
// after reset or when clr_req is pulsed.
module regfile_mp #(
  parameter  int XLEN     = 32,
  parameter  int NREGS    = 32,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_valid,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                clr_req,
  output logic                busy
);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t          state;
  state_t          next_state;
  logic [AW-1:0]   clr_cnt;
  logic [AW-1:0]   next_cnt;
  logic            clr_we;
  logic            wr_drop;
  logic            wr_fire;
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] rd_value [NRD];

  // Clear engine state and sweep counter; reset restarts the sweep at entry 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= next_state;
      clr_cnt <= next_cnt;
    end
  end

  // Sweep every entry once, then sit in IDLE until a clear is requested
  always_comb begin
    next_state = state;
    next_cnt   = clr_cnt;
    case (state)
      CLEAR: begin
        if (clr_cnt == LAST_IDX) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt = clr_cnt + 1'b1;
        end
      end
      IDLE: begin
        if (clr_req) begin
          next_state = CLEAR;
          next_cnt   = '0;
        end
      end
      default: begin
        next_state = CLEAR;
        next_cnt   = '0;
      end
    endcase
  end

  // The engine owns the array while clearing; rst holds it off so the array is untouched during reset
  always_comb begin
    busy   = (state == CLEAR);
    clr_we = (state == CLEAR) && !rst;
  end

  // A write is accepted only in IDLE and never to a hardwired x0
  always_comb begin
    wr_drop = (ZERO_REG != 0) && (wr_addr == '0);
    wr_fire = wr_en && !busy && !wr_drop && !rst;
  end

  // Array update: clear sweep or committed writeback
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs[clr_cnt] <= '0;
    end else if (wr_fire) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Per-port operand: x0 zero first, then same-edge bypass, then stored value
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      if ((ZERO_REG != 0) && (rd_addr[p*AW +: AW] == '0)) begin
        rd_value[p] = '0;
      end else if (wr_fire && (wr_addr == rd_addr[p*AW +: AW])) begin
        rd_value[p] = wr_data;
      end else begin
        rd_value[p] = regs[rd_addr[p*AW +: AW]];
      end
    end
  end

  // Registered read stage; data holds when a port is not serviced
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else begin
      for (int p = 0; p < NRD; p++) begin
        if (rd_en[p] && !busy) begin
          rd_data[p*XLEN +: XLEN] <= rd_value[p];
          rd_valid[p]             <= 1'b1;
        end else begin
          rd_valid[p]             <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table-driven checks of regfile_mp plus hand-written
// sequences for reset/clear timing, clear requests and reset during a clear.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk;
  logic                rst;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_valid;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                clr_req;
  logic                busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  en;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  exp_valid;
    logic [31:0] exp_d0;
    logic [31:0] exp_d1;
  } vec_t;

  vec_t vecs [12];

  regfile_mp #(
    .XLEN(XLEN),
    .NREGS(NREGS),
    .NRD(NRD),
    .ZERO_REG(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .clr_req(clr_req),
    .busy(busy)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic clr);
    rd_en   = en;
    rd_addr = {a1, a0};
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    clr_req = clr;
  endtask

  task automatic idle_inputs();
    apply_stimulus(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  initial begin
    int cnt;

    // Table: {rd_en, addr0, addr1, wr_en, wr_addr, wr_data, exp_valid, exp_d0, exp_d1}
    vecs[0]  = '{2'b11, 5'd1,  5'd31, 1'b0, 5'd0,  32'h0,        2'b11, 32'h0,        32'h0};
    vecs[1]  = '{2'b01, 5'd5,  5'd0,  1'b1, 5'd5,  32'hDEADBEEF, 2'b01, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{2'b11, 5'd5,  5'd5,  1'b0, 5'd0,  32'h0,        2'b11, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[3]  = '{2'b11, 5'd0,  5'd0,  1'b1, 5'd0,  32'h12345678, 2'b11, 32'h0,        32'h0};
    vecs[4]  = '{2'b11, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        2'b11, 32'h0,        32'h0};
    vecs[5]  = '{2'b00, 5'd0,  5'd0,  1'b1, 5'd3,  32'h11,       2'b00, 32'h0,        32'h0};
    vecs[6]  = '{2'b11, 5'd3,  5'd4,  1'b1, 5'd4,  32'h22,       2'b11, 32'h11,       32'h22};
    vecs[7]  = '{2'b11, 5'd4,  5'd4,  1'b0, 5'd0,  32'h0,        2'b11, 32'h22,       32'h22};
    vecs[8]  = '{2'b01, 5'd3,  5'd4,  1'b0, 5'd0,  32'h0,        2'b01, 32'h11,       32'h22};
    vecs[9]  = '{2'b00, 5'd3,  5'd4,  1'b0, 5'd0,  32'h0,        2'b00, 32'h11,       32'h22};
    vecs[10] = '{2'b11, 5'd5,  5'd31, 1'b1, 5'd31, 32'hA5A5A5A5, 2'b11, 32'hDEADBEEF, 32'hA5A5A5A5};
    vecs[11] = '{2'b01, 5'd5,  5'd31, 1'b1, 5'd5,  32'h0,        2'b01, 32'h0,        32'hA5A5A5A5};

    // Reset for two cycles, then measure the initial clear
    rst = 1'b1;
    idle_inputs();
    step();
    check_output("rst busy", {31'b0, busy}, 32'd1);
    check_output("rst valid", {30'b0, rd_valid}, 32'd0);
    step();
    check_output("rst data0", rd_data[31:0], 32'h0);
    check_output("rst data1", rd_data[63:32], 32'h0);
    rst = 1'b0;
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      step();
    end
    check_output("init clear busy cycles", cnt, 32'd32);

    // Every register reads zero after the initial clear
    for (int i = 1; i < 32; i++) begin
      apply_stimulus(2'b11, 5'(i), 5'(32 - i), 1'b0, 5'd0, 32'h0, 1'b0);
      step();
      check_output($sformatf("init zero valid %0d", i), {30'b0, rd_valid}, 32'd3);
      check_output($sformatf("init zero d0 x%0d", i), rd_data[31:0], 32'h0);
      check_output($sformatf("init zero d1 x%0d", 32 - i), rd_data[63:32], 32'h0);
    end

    // Table-driven vectors
    for (int v = 0; v < 12; v++) begin
      apply_stimulus(vecs[v].en, vecs[v].a0, vecs[v].a1, vecs[v].we, vecs[v].wa, vecs[v].wd, 1'b0);
      step();
      check_output($sformatf("vec%0d valid", v), {30'b0, rd_valid}, {30'b0, vecs[v].exp_valid});
      check_output($sformatf("vec%0d d0", v), rd_data[31:0], vecs[v].exp_d0);
      check_output($sformatf("vec%0d d1", v), rd_data[63:32], vecs[v].exp_d1);
    end

    // Fill x1..x31 with nonzero values
    for (int i = 1; i < 32; i++) begin
      apply_stimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'(i), 32'h1000_0000 | i, 1'b0);
      step();
    end
    apply_stimulus(2'b11, 5'd7, 5'd20, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    check_output("fill d0 x7", rd_data[31:0], 32'h1000_0007);
    check_output("fill d1 x20", rd_data[63:32], 32'h1000_0014);

    // Clear request with a read and a write in the same cycle
    apply_stimulus(2'b01, 5'd7, 5'd0, 1'b1, 5'd9, 32'h99, 1'b1);
    step();
    check_output("clr cycle read valid", {30'b0, rd_valid}, 32'd1);
    check_output("clr cycle read d0", rd_data[31:0], 32'h1000_0007);
    check_output("busy after clr_req", {31'b0, busy}, 32'd1);
    cnt = 0;
    while (busy && cnt < 200) begin
      if (cnt == 0) apply_stimulus(2'b11, 5'd7, 5'd8, 1'b0, 5'd0, 32'h0, 1'b0);
      else if (cnt == 31) apply_stimulus(2'b00, 5'd0, 5'd0, 1'b1, 5'd2, 32'hFFFFFFFF, 1'b0);
      else idle_inputs();
      cnt++;
      step();
      if (cnt == 1) check_output("read during busy valid", {30'b0, rd_valid}, 32'd0);
    end
    check_output("clr_req busy cycles", cnt, 32'd32);
    for (int i = 1; i < 32; i++) begin
      apply_stimulus(2'b11, 5'(i), 5'(32 - i), 1'b0, 5'd0, 32'h0, 1'b0);
      step();
      check_output($sformatf("post clr valid %0d", i), {30'b0, rd_valid}, 32'd3);
      check_output($sformatf("post clr d0 x%0d", i), rd_data[31:0], 32'h0);
      check_output($sformatf("post clr d1 x%0d", 32 - i), rd_data[63:32], 32'h0);
    end

    // Reset in the middle of a clear restarts the full sweep
    apply_stimulus(2'b01, 5'd6, 5'd0, 1'b1, 5'd6, 32'h77, 1'b0);
    step();
    check_output("x6 bypass d0", rd_data[31:0], 32'h77);
    apply_stimulus(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    step();
    check_output("busy after second clr_req", {31'b0, busy}, 32'd1);
    idle_inputs();
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    check_output("mid-clear rst busy", {31'b0, busy}, 32'd1);
    check_output("mid-clear rst valid", {30'b0, rd_valid}, 32'd0);
    check_output("mid-clear rst d0", rd_data[31:0], 32'h0);
    rst = 1'b0;
    cnt = 0;
    while (busy && cnt < 200) begin
      if (cnt == 5) apply_stimulus(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
      else idle_inputs();
      cnt++;
      step();
    end
    check_output("mid-clear restart busy cycles", cnt, 32'd32);
    apply_stimulus(2'b11, 5'd6, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0);
    step();
    check_output("x6 after restart valid", {30'b0, rd_valid}, 32'd3);
    check_output("x6 after restart d0", rd_data[31:0], 32'h0);
    check_output("x6 after restart d1", rd_data[63:32], 32'h0);
    idle_inputs();
    step();
    check_output("idle after restart busy", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
